// File: rtl/mem_array_ctrl_if.sv
// mem_array_ctrl_if: bus bundle between the tiny16 bus-control FSM and mem_array_ctrl.
// Latency: none, wires only.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports (controller -> RAM): addr_en, addr, inc_en, wr_en, wr_data, rd_en [, wr_be]
// Ports (RAM -> controller): rd_data, rd_valid, mar_out, wrap
// Optional: TINY16_MEM_BYTE_WR_EN adds wr_be (one enable bit per byte of wr_data).
interface mem_array_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              addr_en;
  logic [ADDR_W-1:0] addr;
  logic              inc_en;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] mar_out;
  logic              wrap;
`ifdef TINY16_MEM_BYTE_WR_EN
  logic [DATA_W/8-1:0] wr_be;
`endif

  modport master (
`ifdef TINY16_MEM_BYTE_WR_EN
    output wr_be,
`endif
    output addr_en, addr, inc_en, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, mar_out, wrap
  );

  modport slave (
`ifdef TINY16_MEM_BYTE_WR_EN
    input  wr_be,
`endif
    input  addr_en, addr, inc_en, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, mar_out, wrap
  );
endinterface

// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl: word-addressed RAM with memory address register (MAR), auto-increment and read pipeline.
// Latency: read accepted in cycle N returns rd_data with a one-cycle rd_valid in cycle N+RD_LAT; writes land at the edge.
// Backpressure: none; reads, writes and MAR loads are accepted every cycle, back-to-back reads at full rate.
// Ports: clk, rst (synchronous, active-high); bus (mem_array_ctrl_if.slave) carries all strobes and data.
// Optional: TINY16_MEM_BYTE_WR_EN enables per-byte write enables (bus.wr_be).
// Parameters: DATA_W (multiple of 8), ADDR_W, DEPTH_LOG2 (<= ADDR_W), RD_LAT (1..4).
module mem_array_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 16,
  parameter int RD_LAT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_array_ctrl_if.slave bus
);
  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]     mar_q, mar_d;
  logic                  wrap_q, wrap_d;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  access;

  // Read pipeline: stage 0 captures the word at the accepting edge, the last stage drives the bus.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  // Upper MAR bits are kept for visibility but never select a word.
  assign idx    = mar_q[DEPTH_LOG2-1:0];
  assign access = bus.wr_en | bus.rd_en;

  // MAR next state: explicit load wins over increment. The increment stays inside the
  // index space, so upper bits clear and DEPTH-1 rolls naturally to 0.
  always_comb begin
    mar_d  = mar_q;
    wrap_d = 1'b0;
    if (bus.addr_en) begin
      mar_d = bus.addr;
    end else if (bus.inc_en && access) begin
      mar_d                  = '0;
      mar_d[DEPTH_LOG2-1:0]  = idx + IDX_ONE;
      wrap_d                 = &idx;
    end
  end

  // Read samples the array before this edge's write lands, giving read-before-write
  // on a same-cycle collision and the fresh word one cycle after a write.
  always_comb begin
    vld_d[0] = bus.rd_en;
    dat_d[0] = mem[idx];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q  <= '0;
      wrap_q <= 1'b0;
      vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      mar_q  <= mar_d;
      wrap_q <= wrap_d;
      vld_q  <= vld_d;
      // Data only moves with a valid, so the output stage holds the last returned word.
      for (int i = 0; i < RD_LAT; i++) begin
        if (vld_d[i]) begin
          dat_q[i] <= dat_d[i];
        end
      end
    end
  end

`ifdef TINY16_MEM_BYTE_WR_EN
  // wr_be == 0 writes nothing, but the strobe still counts as an access for inc_en.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (bus.wr_be[b]) begin
          mem[idx][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      mem[idx] <= bus.wr_data;
    end
  end
`endif

  assign bus.rd_data  = dat_q[RD_LAT-1];
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.mar_out  = mar_q;
  assign bus.wrap     = wrap_q;

endmodule
